// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, output FSM state encoding and the nibble-to-ASCII helper.
// Pure declarations; no logic, no latency, no flow control.
package sha256_pkg;

    localparam int SHA256_DIGEST_BITS  = 256;
    localparam int SHA256_DIGEST_BYTES = SHA256_DIGEST_BITS / 8;

    localparam logic ENC_IDLE = 1'b0;
    localparam logic ENC_SEND = 1'b1;

    typedef enum logic {
        IDLE = ENC_IDLE,
        SEND = ENC_SEND
    } state_t;

    // Lowercase hex digit: 0-9 -> '0'..'9', 10-15 -> 'a'..'f'.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h61 + {4'h0, n} - 8'd10;
    endfunction

endpackage

// File: rtl/sha256_hex_nibble.sv
// Converts one 4-bit nibble to its lowercase ASCII hex character.
// Purely combinational; no latency, no flow control.
module sha256_hex_nibble
    import sha256_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = nibble_to_ascii(nibble);

endmodule

// File: rtl/sha256_digest_serializer.sv
// Captures a finished digest on the core's done pulse and streams it MSB-first as bytes or hex chars.
// First beat 1 clk after capture; dready stalls hold dout/dlast/state, no dready->dout path.
module sha256_digest_serializer
    import sha256_pkg::*;
#(
    parameter int DIGEST_BITS = SHA256_DIGEST_BITS,
    parameter bit HEX_MODE    = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DIGEST_BITS-1:0] digest,
    input  logic                   digest_valid,
    output logic [7:0]             dout,
    output logic                   dvalid,
    output logic                   dlast,
    input  logic                   dready,
    output logic                   busy,
    output logic                   overrun
);

    localparam int BEATS = HEX_MODE ? (2 * DIGEST_BITS / 8) : (DIGEST_BITS / 8);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    state_t                 state, state_nxt;
    logic [DIGEST_BITS-1:0] shreg, shreg_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   overrun_nxt;
    logic                   at_last;
    logic                   accept;
    logic [7:0]             sym;

    assign at_last = (cnt == LAST_BEAT);
    assign accept  = (state == SEND) && dready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            cnt     <= cnt_nxt;
            overrun <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        cnt_nxt     = cnt;
        overrun_nxt = overrun;
        case (state)
            IDLE: begin
                if (digest_valid) begin
                    shreg_nxt = digest;
                    cnt_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (accept && at_last) begin
                    // A done pulse coinciding with the final handshake chains the next digest with no gap.
                    if (digest_valid) begin
                        shreg_nxt = digest;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    if (digest_valid)
                        overrun_nxt = 1'b1;
                    if (accept) begin
                        cnt_nxt = cnt + CW'(1);
                        if (!HEX_MODE || cnt[0])
                            shreg_nxt = {shreg[DIGEST_BITS-9:0], 8'h00};
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    generate
        if (HEX_MODE) begin : g_hex
            logic [3:0] nib;
            // Even beats carry the high nibble of the current byte, odd beats the low nibble.
            assign nib = cnt[0] ? shreg[DIGEST_BITS-5 -: 4] : shreg[DIGEST_BITS-1 -: 4];
            sha256_hex_nibble u_hex_nibble (
                .nibble (nib),
                .ascii  (sym)
            );
        end else begin : g_raw
            assign sym = shreg[DIGEST_BITS-1 -: 8];
        end
    endgenerate

    assign dvalid = (state == SEND);
    assign busy   = (state == SEND);
    assign dlast  = (state == SEND) && at_last;
    assign dout   = (state == SEND) ? sym : 8'h00;

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// Scoreboard bench: raw and hex instances, expected beats queued at stimulus time, popped by monitors.
module tb_sha256_digest_serializer;

    localparam logic [255:0] D = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic         clk = 1'b0;
    logic         rst_n;

    logic [255:0] r_dig, h_dig;
    logic         r_dv, h_dv, r_rdy, h_rdy;
    logic [7:0]   r_dout, h_dout;
    logic         r_dvalid, h_dvalid, r_dlast, h_dlast;
    logic         r_busy, h_busy, r_ovr, h_ovr;

    int           checks   = 0;
    int           failures = 0;
    logic [8:0]   qr[$];
    logic [8:0]   qh[$];
    int           r_idx = 0;
    int           h_idx = 0;
    logic [8:0]   r_e, h_e;

    always #5 clk = ~clk;

    sha256_digest_serializer #(.DIGEST_BITS(256), .HEX_MODE(1'b0)) dut_raw (
        .clk(clk), .rst_n(rst_n), .digest(r_dig), .digest_valid(r_dv),
        .dout(r_dout), .dvalid(r_dvalid), .dlast(r_dlast), .dready(r_rdy),
        .busy(r_busy), .overrun(r_ovr)
    );

    sha256_digest_serializer #(.DIGEST_BITS(256), .HEX_MODE(1'b1)) dut_hex (
        .clk(clk), .rst_n(rst_n), .digest(h_dig), .digest_valid(h_dv),
        .dout(h_dout), .dvalid(h_dvalid), .dlast(h_dlast), .dready(h_rdy),
        .busy(h_busy), .overrun(h_ovr)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: raw beats are the digest bytes MSB-first; hex beats are its lowercase hex text.
    task automatic push_raw(input logic [255:0] d);
        for (int i = 0; i < 32; i++)
            qr.push_back({(i == 31), d[255 - 8*i -: 8]});
    endtask

    task automatic push_hex(input logic [255:0] d);
        string s;
        s = $sformatf("%h", d);
        for (int i = 0; i < 64; i++)
            qh.push_back({(i == 63), 8'(s[i])});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_digest();
        logic [255:0] d;
        for (int i = 0; i < 8; i++)
            d[32*i +: 32] = $urandom;
        return d;
    endfunction

    task automatic pulse_raw(input logic [255:0] d);
        r_dig = d; r_dv = 1'b1; push_raw(d);
        tick();
        r_dv = 1'b0;
    endtask

    task automatic pulse_hex(input logic [255:0] d);
        h_dig = d; h_dv = 1'b1; push_hex(d);
        tick();
        h_dv = 1'b0;
    endtask

    task automatic drain_raw(input bit rnd, input string name);
        int n = 0;
        while ((qr.size() != 0 || r_dvalid) && n < 2000) begin
            if (rnd) r_rdy = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        r_rdy = 1'b1;
        if (n >= 2000) begin
            checks++; failures++;
            $display("FAIL %s_drain_timeout actual=%0d required=<2000", name, n);
        end
        check({name, "_dvalid_end"}, 8'(r_dvalid), 8'h0);
        check({name, "_busy_end"}, 8'(r_busy), 8'h0);
        check({name, "_dlast_end"}, 8'(r_dlast), 8'h0);
    endtask

    task automatic drain_hex(input bit rnd, input string name);
        int n = 0;
        while ((qh.size() != 0 || h_dvalid) && n < 2000) begin
            if (rnd) h_rdy = ($urandom_range(0, 3) != 0);
            tick();
            n++;
        end
        h_rdy = 1'b1;
        if (n >= 2000) begin
            checks++; failures++;
            $display("FAIL %s_drain_timeout actual=%0d required=<2000", name, n);
        end
        check({name, "_dvalid_end"}, 8'(h_dvalid), 8'h0);
        check({name, "_busy_end"}, 8'(h_busy), 8'h0);
    endtask

    task automatic wait_idx_raw(input int k);
        int n = 0;
        while (r_idx != k && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) begin
            checks++; failures++;
            $display("FAIL wait_beat_%0d actual=%0d required=%0d", k, r_idx, k);
        end
    endtask

    // Monitors: every presented beat must match the queue head; a handshake pops it.
    always @(negedge clk) begin
        if (!rst_n) begin
            qr.delete();
            r_idx = 0;
        end else if (r_dvalid) begin
            if (qr.size() == 0) begin
                checks++; failures++;
                $display("FAIL raw_unexpected_beat actual=%0h required=none", r_dout);
            end else begin
                r_e = qr[0];
                check("raw_dout", r_dout, r_e[7:0]);
                check("raw_dlast", 8'(r_dlast), 8'(r_e[8]));
                if (r_rdy) begin
                    void'(qr.pop_front());
                    r_idx = r_e[8] ? 0 : r_idx + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            qh.delete();
            h_idx = 0;
        end else if (h_dvalid) begin
            if (qh.size() == 0) begin
                checks++; failures++;
                $display("FAIL hex_unexpected_beat actual=%0h required=none", h_dout);
            end else begin
                h_e = qh[0];
                check("hex_dout", h_dout, h_e[7:0]);
                check("hex_dlast", 8'(h_dlast), 8'(h_e[8]));
                if (h_rdy) begin
                    void'(qh.pop_front());
                    h_idx = h_e[8] ? 0 : h_idx + 1;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        r_dig = '0; r_dv = 1'b0; r_rdy = 1'b1;
        h_dig = '0; h_dv = 1'b0; h_rdy = 1'b1;
        repeat (3) tick();

        check("rst_raw_dvalid", 8'(r_dvalid), 8'h0);
        check("rst_raw_dout", r_dout, 8'h00);
        check("rst_raw_dlast", 8'(r_dlast), 8'h0);
        check("rst_raw_busy", 8'(r_busy), 8'h0);
        check("rst_raw_overrun", 8'(r_ovr), 8'h0);
        check("rst_hex_dvalid", 8'(h_dvalid), 8'h0);
        check("rst_hex_dout", h_dout, 8'h00);
        rst_n = 1'b1;
        tick();

        // Raw D at full rate
        check("t1_idle_dvalid", 8'(r_dvalid), 8'h0);
        pulse_raw(D);
        check("t1_dvalid_latency", 8'(r_dvalid), 8'h1);
        check("t1_busy_latency", 8'(r_busy), 8'h1);
        drain_raw(1'b0, "t1");
        check("t1_overrun", 8'(r_ovr), 8'h0);

        // Stall on beat 10
        pulse_raw(D);
        wait_idx_raw(10);
        r_rdy = 1'b0;
        repeat (5) tick();
        check("t3_held_dout", r_dout, 8'h40);
        check("t3_held_dvalid", 8'(r_dvalid), 8'h1);
        r_rdy = 1'b1;
        drain_raw(1'b0, "t3");

        // Zero-bubble chaining after an all-zero digest
        pulse_raw('0);
        begin
            int n = 0;
            while (!r_dlast && n < 200) begin
                tick();
                n++;
            end
            if (n >= 200) begin
                checks++; failures++;
                $display("FAIL t4_wait_last actual=%0d required=<200", n);
            end
        end
        r_dig = D; r_dv = 1'b1; push_raw(D);
        tick();
        r_dv = 1'b0;
        check("t4_no_gap_dvalid", 8'(r_dvalid), 8'h1);
        check("t4_first_byte", r_dout, 8'hba);
        check("t4_overrun", 8'(r_ovr), 8'h0);
        drain_raw(1'b0, "t4");

        // Collision during beat 5
        pulse_raw(D);
        wait_idx_raw(5);
        r_dig = ~D; r_dv = 1'b1;
        tick();
        r_dv = 1'b0;
        check("t5_overrun_set", 8'(r_ovr), 8'h1);
        drain_raw(1'b0, "t5");
        check("t5_overrun_sticky", 8'(r_ovr), 8'h1);

        // Reset mid-stream
        pulse_raw(D);
        wait_idx_raw(20);
        rst_n = 1'b0;
        #1;
        check("t6_async_dvalid", 8'(r_dvalid), 8'h0);
        check("t6_async_busy", 8'(r_busy), 8'h0);
        check("t6_async_overrun", 8'(r_ovr), 8'h0);
        check("t6_async_dlast", 8'(r_dlast), 8'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        pulse_raw(D);
        check("t6_restart_byte", r_dout, 8'hba);
        drain_raw(1'b0, "t6");

        // Random digests with random backpressure
        for (int k = 0; k < 4; k++) begin
            pulse_raw(rand_digest());
            drain_raw(1'b1, "rraw");
        end
        check("rraw_overrun", 8'(r_ovr), 8'h0);

        // Hex mode
        pulse_hex(D);
        check("t2_hex_dvalid", 8'(h_dvalid), 8'h1);
        check("t2_hex_first", h_dout, 8'h62);
        drain_hex(1'b0, "t2");
        for (int k = 0; k < 3; k++) begin
            pulse_hex(rand_digest());
            drain_hex(1'b1, "rhex");
        end
        check("rhex_overrun", 8'(h_ovr), 8'h0);

        // digest_valid held three cycles in IDLE: first cycle captures, the rest overrun
        h_dig = D; h_dv = 1'b1; push_hex(D);
        repeat (3) tick();
        h_dv = 1'b0;
        check("hold_overrun", 8'(h_ovr), 8'h1);
        drain_hex(1'b0, "hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
